alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
// - 8-bit integer ALU for the MIPS_Lite datapath. It sits between the register-file read ports and the write-back mux.
// - Selects one of eight operations on operands A and B with a 3-bit op_code.
// - Result is registered: one clock of latency, cleared by synchronous reset.
//
// PARAMETERS
// - WIDTH   8   operand and result width in bits; all behaviour below is stated for WIDTH=8
//
// PORTS
// - clk      in   1      single clock; all state updates on its rising edge
// - rst      in   1      reset, synchronous, active-high
// - A        in   WIDTH  operand 1, unsigned
// - B        in   WIDTH  operand 2, unsigned
// - op_code  in   3      operation select, see BEHAVIOUR
// - result   out  WIDTH  registered operation result
//
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high (rst).
// - Reset
//   - On a rising clk edge with rst=1, result <= 0.
//   - rst has priority over any operation presented in the same cycle.
//   - The first result after rst deasserts reflects the inputs sampled at that edge.
// - Latency and throughput
//   - Inputs are sampled on every rising edge with rst=0.
//   - result shows f(A,B,op_code) from that edge until the next edge.
//   - Latency is 1 cycle, throughput is 1 op/cycle, no handshake.
//   - result is stable between edges; there is no combinational path from inputs to result.
// - Operations (all unsigned, modulo 2^WIDTH):
//   - 000 ADD: (A+B)[7:0]; carry discarded, so 200+100 gives 44.
//   - 001 SUB: (A-B)[7:0]; borrow wraps, so 5-64 gives 197 (8'hC5).
//   - 010 MUL: low 8 bits of the 16-bit product, so 20*20 gives 144.
//   - 011 DIV: floor(A/B), remainder discarded, so 20/8 gives 2.
//     - B==0 gives result 8'hFF (all ones).
//   - 100 AND: A & B, bitwise.
//   - 101 OR: A | B, bitwise.
//   - 110 XOR: A ^ B, bitwise.
//   - 111 ZERO: result 0, regardless of A and B.
// - Division
//   - Fully combinational within one cycle: restoring long division, WIDTH iterations.
//   - It must close timing at the datapath clock; no multicycle path.
// - X or undefined inputs need no defined handling. op_code is fully decoded, so there is no default-case ambiguity.
//
// STRUCTURE
// - Shared package alu_pkg:
//   - localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110, OP_ZERO=3'b111.
//   - DIV_BY_ZERO_RESULT = all ones.
//   - The decoder and the bench use these constants.
// - Sub-module alu_div (combinational, WIDTH parameter):
//   - Inputs: dividend, divisor.
//   - Outputs: quotient, remainder, div_by_zero.
//   - Implemented as an unrolled restoring divider.
// - Top level: combinational operation mux feeding one WIDTH-bit result register with synchronous reset.
//
// TESTING
// - Each case applies inputs, waits one rising edge, then checks result.
// - Reset: drive rst=1 with A=40, B=64, op=000 -> result==0. Release rst -> next edge result==104.
// - Arithmetic:
//   - ADD 40+64 -> 104; ADD 200+100 -> 44 (wrap).
//   - SUB 64-5 -> 59; SUB 5-64 -> 197.
//   - MUL 10*3 -> 30; MUL 20*20 -> 144.
// - Division:
//   - DIV 20/5 -> 4; DIV 20/8 -> 2 (truncate).
//   - DIV 255/1 -> 255; DIV 7/0 -> 8'hFF.
// - Logic:
//   - AND 11010110 & 01001010 -> 01000010.
//   - OR 01101010 | 00101011 -> 01101011.
//   - XOR 10110111 ^ 10011110 -> 00101001.
//   - ZERO 01111011,01001001 -> 0.
// - Back-to-back: change op every cycle (ADD, SUB, MUL, DIV). Each result appears exactly one edge after its inputs. Assert rst mid-stream -> 0 on that edge.
// - Random: 10k random A/B/op compared against a reference model that uses alu_pkg constants.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared operation encodings and constants for the MIPS_Lite ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    localparam logic [ALU_WIDTH-1:0] DIV_BY_ZERO_RESULT = '1;

endpackage

// File: rtl/alu_div.sv
// Unsigned unrolled restoring divider, WIDTH quotient bits per evaluation.
// Latency: purely combinational, no state.
// Backpressure: none, output follows inputs.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    // Partial remainder carries one extra bit so the trial compare never overflows.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem    = rem - {1'b0, divisor};
                quo[i] = 1'b1;
            end
        end
    end

    assign quotient    = quo;
    assign remainder   = rem[WIDTH-1:0];
    assign div_by_zero = (divisor == '0);

endmodule

// File: rtl/alu.sv
// 8-bit integer ALU: op_code selects one of eight ops on A/B, result registered.
// Latency: 1 clk, throughput 1 op/clk.
// Backpressure: none, inputs sampled every edge, no handshake.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op_code,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem_unused;
    logic             div_by_zero;
    logic [WIDTH-1:0] result_nxt;

    alu_div #(.WIDTH(WIDTH)) u_div (
        .dividend    (A),
        .divisor     (B),
        .quotient    (div_quo),
        .remainder   (div_rem_unused),
        .div_by_zero (div_by_zero)
    );

    // Arithmetic is evaluated at WIDTH bits, so carries/borrows/high product bits drop.
    always_comb begin
        result_nxt = '0;
        case (op_code)
            OP_ADD:  result_nxt = A + B;
            OP_SUB:  result_nxt = A - B;
            OP_MUL:  result_nxt = A * B;
            OP_DIV:  result_nxt = div_by_zero ? WIDTH'(DIV_BY_ZERO_RESULT) : div_quo;
            OP_AND:  result_nxt = A & B;
            OP_OR:   result_nxt = A | B;
            OP_XOR:  result_nxt = A ^ B;
            OP_ZERO: result_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus queues expected results, monitor checks each edge.
module tb_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic [2:0] op  = OP_ZERO;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (a),
        .B       (b),
        .op_code (op),
        .result  (result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] o);
        int ix;
        int iy;
        ix = int'(x);
        iy = int'(y);
        case (o)
            OP_ADD:  return 8'((ix + iy) % 256);
            OP_SUB:  return 8'((ix - iy + 256) % 256);
            OP_MUL:  return 8'((ix * iy) % 256);
            OP_DIV:  return (iy == 0) ? DIV_BY_ZERO_RESULT : 8'(ix / iy);
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    // Present one set of inputs for the next edge and record what that edge must produce.
    task automatic drive(input logic r, input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] o, input string nm, input logic [7:0] e);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        op  = o;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (result !== e) begin
                    bad++;
                    $display("FAIL %s: result=%0d expected=%0d", nm, result, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] ro;
        int         waited;

        drive(1'b1, 8'd40, 8'd64, OP_ADD, "reset", 8'd0);
        drive(1'b0, 8'd40, 8'd64, OP_ADD, "after_reset_add", 8'd104);

        drive(1'b0, 8'd200, 8'd100, OP_ADD, "add_wrap", 8'd44);
        drive(1'b0, 8'd64, 8'd5, OP_SUB, "sub", 8'd59);
        drive(1'b0, 8'd5, 8'd64, OP_SUB, "sub_wrap", 8'd197);
        drive(1'b0, 8'd10, 8'd3, OP_MUL, "mul", 8'd30);
        drive(1'b0, 8'd20, 8'd20, OP_MUL, "mul_trunc", 8'd144);
        drive(1'b0, 8'd20, 8'd5, OP_DIV, "div", 8'd4);
        drive(1'b0, 8'd20, 8'd8, OP_DIV, "div_trunc", 8'd2);
        drive(1'b0, 8'd255, 8'd1, OP_DIV, "div_by_one", 8'd255);
        drive(1'b0, 8'd7, 8'd0, OP_DIV, "div_by_zero", 8'hFF);
        drive(1'b0, 8'd255, 8'd255, OP_DIV, "div_equal", 8'd1);
        drive(1'b0, 8'd3, 8'd200, OP_DIV, "div_small", 8'd0);
        drive(1'b0, 8'b11010110, 8'b01001010, OP_AND, "and", 8'b01000010);
        drive(1'b0, 8'b01101010, 8'b00101011, OP_OR, "or", 8'b01101011);
        drive(1'b0, 8'b10110111, 8'b10011110, OP_XOR, "xor", 8'b00101001);
        drive(1'b0, 8'b01111011, 8'b01001001, OP_ZERO, "zero", 8'd0);

        drive(1'b0, 8'd9, 8'd4, OP_ADD, "b2b_add", 8'd13);
        drive(1'b0, 8'd9, 8'd4, OP_SUB, "b2b_sub", 8'd5);
        drive(1'b0, 8'd9, 8'd4, OP_MUL, "b2b_mul", 8'd36);
        drive(1'b0, 8'd9, 8'd4, OP_DIV, "b2b_div", 8'd2);
        drive(1'b1, 8'd9, 8'd4, OP_ADD, "b2b_reset", 8'd0);
        drive(1'b0, 8'd100, 8'd50, OP_SUB, "b2b_after_reset", 8'd50);

        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ro = 3'($urandom_range(0, 7));
            drive(1'b0, ra, rb, ro, "random", ref_alu(ra, rb, ro));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
